// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the primary
//   pipeline writeback and an auxiliary long-latency unit (mult/div, debug).
//   Auxiliary writes are held in a small FIFO. They drain when the primary
//   port is idle. They are forced out when a primary write would overtake an
//   older queued write to the same register (WAW). They are also forced out
//   when the queue head has waited STARVE_LIMIT cycles.
//
// Parameters
//   DEPTH         auxiliary FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  cycles a queued head may wait before a forced drain (>= 1)
//
// Ports
//   CLK, nRST                    clock, asynchronous active-low reset
//   pri_wen/pri_wsel/pri_wdat    primary writeback request
//   aux_req/aux_wsel/aux_wdat    auxiliary write request
//   aux_ack                      auxiliary request accepted this cycle
//   pri_stall                    primary write not performed; hold pri_*
//   rf_wen/rf_wsel/rf_wdat       register file write port
//   pend_mask                    bit n set while a queued entry targets rn
//   q_count                      number of queued auxiliary entries
//
// Optional feature (macro RF_ARB_STATS_EN)
//   aux_grant_cnt  saturating count of auxiliary pops
//   stall_cnt      saturating count of cycles with pri_stall=1
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       pri_wen,
  input  logic [4:0]                 pri_wsel,
  input  logic [31:0]                pri_wdat,
  input  logic                       aux_req,
  input  logic [4:0]                 aux_wsel,
  input  logic [31:0]                aux_wdat,
  output logic                       aux_ack,
  output logic                       pri_stall,
  output logic                       rf_wen,
  output logic [4:0]                 rf_wsel,
  output logic [31:0]                rf_wdat,
  output logic [31:0]                pend_mask,
  output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]                aux_grant_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PRI,
    SRC_AUX
  } src_e;

  logic [4:0]       fifo_wsel [DEPTH];
  logic [31:0]      fifo_wdat [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic hazard;
  logic force_drain;
  src_e src;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend_mask[fifo_wsel[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign hazard      = pri_wen && (pri_wsel != 5'd0) && pend_mask[pri_wsel];
  assign force_drain = !empty && (starve == SW'(STARVE_LIMIT));

  // The request-driven outputs are qualified with nRST so that the port is
  // silent while reset is held, even if the requesters keep driving.
  assign pri_stall = nRST && pri_wen && (hazard || force_drain);

  // The full check uses the registered count, so a slot freed by this
  // cycle's pop is not reusable until the next cycle.
  assign aux_ack = nRST && aux_req && !full;
  // A write to r0 is acknowledged but discarded.
  assign push    = aux_ack && (aux_wsel != 5'd0);

  always_comb begin
    src = SRC_NONE;
    if (!nRST)          src = SRC_NONE;
    else if (pri_stall) src = SRC_AUX;
    else if (pri_wen)   src = SRC_PRI;
    else if (!empty)    src = SRC_AUX;
  end

  assign pop = (src == SRC_AUX);

  always_comb begin
    rf_wen  = 1'b0;
    rf_wsel = '0;
    rf_wdat = '0;
    unique case (src)
      SRC_PRI: begin
        rf_wen  = 1'b1;
        rf_wsel = pri_wsel;
        rf_wdat = pri_wdat;
      end
      SRC_AUX: begin
        rf_wen  = 1'b1;
        rf_wsel = fifo_wsel[rd_ptr];
        rf_wdat = fifo_wdat[rd_ptr];
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
      valid  <= '0;
    end else begin
      // rd_ptr and wr_ptr only coincide when empty (no pop) or full (no
      // push), so the two valid updates never target the same slot.
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + PW'(1);
        valid[wr_ptr] <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (pop || empty)                      starve <= '0;
      else if (starve != SW'(STARVE_LIMIT))  starve <= starve + SW'(1);
    end
  end

  // NOTE: the payload array has no reset; the valid bits alone qualify it,
  // so leaving it unreset lets it map onto plain storage.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_wsel[wr_ptr] <= aux_wsel;
      fifo_wdat[wr_ptr] <= aux_wdat;
    end
  end

  assign q_count = count;

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      aux_grant_cnt <= '0;
      stall_cnt     <= '0;
    end else begin
      if (pop && (aux_grant_cnt != 16'hFFFF))   aux_grant_cnt <= aux_grant_cnt + 16'd1;
      if (pri_stall && (stall_cnt != 16'hFFFF)) stall_cnt     <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        pri_wen = 1'b0;
  logic [4:0]  pri_wsel = '0;
  logic [31:0] pri_wdat = '0;
  logic        aux_req = 1'b0;
  logic [4:0]  aux_wsel = '0;
  logic [31:0] aux_wdat = '0;
  logic        aux_ack;
  logic        pri_stall;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [31:0] pend_mask;
  logic [2:0]  q_count;
`ifdef RF_ARB_STATS_EN
  logic [15:0] aux_grant_cnt;
  logic [15:0] stall_cnt;
  int          exp_grants = 0;
  int          exp_stalls = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .pri_wen   (pri_wen),
    .pri_wsel  (pri_wsel),
    .pri_wdat  (pri_wdat),
    .aux_req   (aux_req),
    .aux_wsel  (aux_wsel),
    .aux_wdat  (aux_wdat),
    .aux_ack   (aux_ack),
    .pri_stall (pri_stall),
    .rf_wen    (rf_wen),
    .rf_wsel   (rf_wsel),
    .rf_wdat   (rf_wdat),
    .pend_mask (pend_mask),
    .q_count   (q_count)
`ifdef RF_ARB_STATS_EN
    ,
    .aux_grant_cnt (aux_grant_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } ent_t;

  typedef struct {
    bit          ack;
    bit          stall;
    bit          wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [31:0] pend;
    bit          push;
    bit          pop;
  } exp_t;

  ent_t        mq[$];           // queued auxiliary writes, oldest first
  int          head_wait = 0;   // cycles the head has waited undrained
  logic [31:0] exp_rf [32];     // register file as the model says it should be
  logic [31:0] tb_rf  [32];     // register file as built from DUT writes
  ent_t        wlog[$];         // every write seen on the DUT rf port
  bit          last_stall = 0;

  function automatic exp_t predict();
    exp_t e;
    bit   hz;
    bit   frc;
    e = '{default: '0};
    e.ack  = aux_req && (mq.size() < DEPTH);
    e.push = e.ack && (aux_wsel != 5'd0);
    foreach (mq[i]) e.pend[mq[i].wsel] = 1'b1;
    hz  = pri_wen && (pri_wsel != 5'd0) && e.pend[pri_wsel];
    frc = (mq.size() > 0) && (head_wait >= LIMIT);
    e.stall = pri_wen && (hz || frc);
    if (e.stall || (!pri_wen && mq.size() > 0)) begin
      e.wen  = 1'b1;
      e.wsel = mq[0].wsel;
      e.wdat = mq[0].wdat;
      e.pop  = 1'b1;
    end else if (pri_wen) begin
      e.wen  = 1'b1;
      e.wsel = pri_wsel;
      e.wdat = pri_wdat;
    end
    return e;
  endfunction

  exp_t me_upd;
  int   was_size;

  initial begin
    for (int r = 0; r < 32; r++) begin
      exp_rf[r] = '0;
      tb_rf[r]  = '0;
    end
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) begin
        mq.delete();
        head_wait = 0;
`ifdef RF_ARB_STATS_EN
        exp_grants = 0;
        exp_stalls = 0;
`endif
      end else begin
        me_upd   = predict();
        was_size = mq.size();
        if (me_upd.wen && me_upd.wsel != 5'd0) exp_rf[me_upd.wsel] = me_upd.wdat;
`ifdef RF_ARB_STATS_EN
        if (me_upd.pop && exp_grants < 16'hFFFF) exp_grants++;
        if (me_upd.stall && exp_stalls < 16'hFFFF) exp_stalls++;
`endif
        if (me_upd.pop) void'(mq.pop_front());
        if (me_upd.push) mq.push_back('{aux_wsel, aux_wdat});
        if (me_upd.pop || was_size == 0) head_wait = 0;
        else if (head_wait < LIMIT) head_wait++;
      end
    end
  end

  // Capture DUT writes mid-cycle, when inputs and outputs are settled.
  initial forever begin
    @(negedge CLK);
    if (nRST && rf_wen) begin
      wlog.push_back('{rf_wsel, rf_wdat});
      if (rf_wsel != 5'd0) tb_rf[rf_wsel] = rf_wdat;
    end
  end

  // Cycle-by-cycle scoreboard against the model.
  exp_t me_mon;
  initial forever begin
    @(negedge CLK);
    if (nRST) begin
      me_mon = predict();
      last_stall = me_mon.stall;
      n_cmp++;
      if (aux_ack !== me_mon.ack) begin
        n_err++; $display("FAIL mon_aux_ack t=%0t got=%b exp=%b", $time, aux_ack, me_mon.ack);
      end
      n_cmp++;
      if (pri_stall !== me_mon.stall) begin
        n_err++; $display("FAIL mon_pri_stall t=%0t got=%b exp=%b", $time, pri_stall, me_mon.stall);
      end
      n_cmp++;
      if ({rf_wen, rf_wsel, rf_wdat} !== {me_mon.wen, me_mon.wsel, me_mon.wdat}) begin
        n_err++; $display("FAIL mon_rf_port t=%0t got=%b/%0d/%h exp=%b/%0d/%h", $time,
                          rf_wen, rf_wsel, rf_wdat, me_mon.wen, me_mon.wsel, me_mon.wdat);
      end
      n_cmp++;
      if (pend_mask !== me_mon.pend) begin
        n_err++; $display("FAIL mon_pend_mask t=%0t got=%h exp=%h", $time, pend_mask, me_mon.pend);
      end
      n_cmp++;
      if (q_count !== 3'(mq.size())) begin
        n_err++; $display("FAIL mon_q_count t=%0t got=%0d exp=%0d", $time, q_count, mq.size());
      end
`ifdef RF_ARB_STATS_EN
      n_cmp++;
      if ({aux_grant_cnt, stall_cnt} !== {16'(exp_grants), 16'(exp_stalls)}) begin
        n_err++; $display("FAIL mon_stats t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                          aux_grant_cnt, stall_cnt, exp_grants, exp_stalls);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    pri_wen = 1'b0; pri_wsel = '0; pri_wdat = '0;
    aux_req = 1'b0; aux_wsel = '0; aux_wdat = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #12;
    n_cmp++;
    if ({aux_ack, pri_stall, rf_wen, rf_wsel, rf_wdat, pend_mask, q_count} !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%b/%b/%b/%0d/%h/%h/%0d exp=all zero",
                        aux_ack, pri_stall, rf_wen, rf_wsel, rf_wdat, pend_mask, q_count);
    end
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({rf_wen, q_count, pend_mask} !== '0) begin
      n_err++; $display("FAIL reset_release got wen=%b q=%0d pend=%h exp=0/0/0", rf_wen, q_count, pend_mask);
    end
    tick();
  endtask

  task automatic test_aux_single();
    aux_req = 1'b1; aux_wsel = 5'd5; aux_wdat = 32'hDEADBEEF;
    @(negedge CLK);
    n_cmp++;
    if (aux_ack !== 1'b1 || rf_wen !== 1'b0) begin
      n_err++; $display("FAIL single_accept got ack=%b wen=%b exp ack=1 wen=0", aux_ack, rf_wen);
    end
    tick();
    aux_req = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({rf_wen, rf_wsel, rf_wdat, pend_mask} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0020}) begin
      n_err++; $display("FAIL single_drain got %b/%0d/%h pend=%h exp 1/5/deadbeef pend=00000020",
                        rf_wen, rf_wsel, rf_wdat, pend_mask);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if ({q_count, pend_mask, rf_wen} !== '0) begin
      n_err++; $display("FAIL single_after got q=%0d pend=%h wen=%b exp 0/0/0", q_count, pend_mask, rf_wen);
    end
    tick();
  endtask

  task automatic test_starve();
    pri_wen = 1'b1; pri_wsel = 5'd1; pri_wdat = 32'h0000_0101;
    aux_req = 1'b1; aux_wsel = 5'd7; aux_wdat = 32'h7777_7777;
    @(negedge CLK);
    tick();
    aux_req = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (pri_stall !== 1'b0 || rf_wsel !== 5'd1) begin
        n_err++; $display("FAIL starve_wait[%0d] got stall=%b wsel=%0d exp stall=0 wsel=1", k, pri_stall, rf_wsel);
      end
      tick();
    end
    @(negedge CLK);
    n_cmp++;
    if ({pri_stall, rf_wsel, rf_wdat} !== {1'b1, 5'd7, 32'h7777_7777}) begin
      n_err++; $display("FAIL starve_force got stall=%b wsel=%0d dat=%h exp 1/7/77777777", pri_stall, rf_wsel, rf_wdat);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if ({pri_stall, rf_wsel, q_count} !== {1'b0, 5'd1, 3'd0}) begin
      n_err++; $display("FAIL starve_resume got stall=%b wsel=%0d q=%0d exp 0/1/0", pri_stall, rf_wsel, q_count);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_hazard();
    pri_wen = 1'b1; pri_wsel = 5'd2; pri_wdat = 32'h22;
    aux_req = 1'b1; aux_wsel = 5'd9; aux_wdat = 32'hAA;
    @(negedge CLK);
    tick();
    aux_req = 1'b0; pri_wsel = 5'd9; pri_wdat = 32'h11;
    @(negedge CLK);
    n_cmp++;
    if ({pri_stall, rf_wsel, rf_wdat} !== {1'b1, 5'd9, 32'hAA}) begin
      n_err++; $display("FAIL hazard_stall got stall=%b wsel=%0d dat=%h exp 1/9/aa", pri_stall, rf_wsel, rf_wdat);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if ({pri_stall, rf_wsel, rf_wdat} !== {1'b0, 5'd9, 32'h11}) begin
      n_err++; $display("FAIL hazard_pri got stall=%b wsel=%0d dat=%h exp 0/9/11", pri_stall, rf_wsel, rf_wdat);
    end
    tick();
    idle_inputs();
    @(negedge CLK);
    n_cmp++;
    if (tb_rf[9] !== 32'h11) begin
      n_err++; $display("FAIL hazard_final_r9 got=%h exp=00000011", tb_rf[9]);
    end
    tick();
  endtask

  task automatic test_full();
    ent_t exp_q[$];
    ent_t got_q[$];
    int   waited;
    bit   acked;
    wlog.delete();
    pri_wen = 1'b1; pri_wsel = 5'd3; pri_wdat = 32'h33;
    for (int i = 0; i < DEPTH; i++) begin
      aux_req = 1'b1; aux_wsel = 5'(10 + i); aux_wdat = $urandom;
      exp_q.push_back('{aux_wsel, aux_wdat});
      @(negedge CLK);
      n_cmp++;
      if (aux_ack !== 1'b1) begin
        n_err++; $display("FAIL full_fill[%0d] got ack=%b exp=1", i, aux_ack);
      end
      tick();
    end
    aux_wsel = 5'd14; aux_wdat = $urandom;
    @(negedge CLK);
    n_cmp++;
    if ({aux_ack, q_count} !== {1'b0, 3'd4}) begin
      n_err++; $display("FAIL full_reject got ack=%b q=%0d exp ack=0 q=4", aux_ack, q_count);
    end
    acked  = 1'b0;
    waited = 0;
    while (!acked && waited < 30) begin
      tick();
      waited++;
      @(negedge CLK);
      acked = aux_ack;
    end
    n_cmp++;
    if (!acked) begin
      n_err++; $display("FAIL full_ack_timeout got no ack in %0d cycles exp ack", waited);
    end else begin
      exp_q.push_back('{aux_wsel, aux_wdat});
    end
    tick();
    idle_inputs();
    repeat (DEPTH + 2) tick();
    foreach (wlog[i]) if (wlog[i].wsel >= 5'd10 && wlog[i].wsel <= 5'd14) got_q.push_back(wlog[i]);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL full_drain_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if ({got_q[i].wsel, got_q[i].wdat} !== {exp_q[i].wsel, exp_q[i].wdat}) begin
          n_err++; $display("FAIL full_order[%0d] got=%0d/%h exp=%0d/%h", i,
                            got_q[i].wsel, got_q[i].wdat, exp_q[i].wsel, exp_q[i].wdat);
        end
      end
    end
  endtask

  task automatic test_r0_drop();
    aux_req = 1'b1; aux_wsel = 5'd0; aux_wdat = 32'hFFFF_0000;
    @(negedge CLK);
    n_cmp++;
    if ({aux_ack, q_count} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL r0_accept got ack=%b q=%0d exp 1/0", aux_ack, q_count);
    end
    tick();
    aux_req = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({q_count, rf_wen, pend_mask} !== '0) begin
      n_err++; $display("FAIL r0_dropped got q=%0d wen=%b pend=%h exp 0/0/0", q_count, rf_wen, pend_mask);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pri_wen = 1'b1; pri_wsel = 5'd3; pri_wdat = 32'h3;
    for (int i = 0; i < 3; i++) begin
      aux_req = 1'b1; aux_wsel = 5'(20 + i); aux_wdat = $urandom;
      tick();
    end
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({q_count, pend_mask, rf_wen, aux_ack, pri_stall} !== '0) begin
      n_err++; $display("FAIL midreset_outputs got q=%0d pend=%h wen=%b ack=%b stall=%b exp all 0",
                        q_count, pend_mask, rf_wen, aux_ack, pri_stall);
    end
`ifdef RF_ARB_STATS_EN
    n_cmp++;
    if ({aux_grant_cnt, stall_cnt} !== 32'd0) begin
      n_err++; $display("FAIL midreset_stats got=%0d/%0d exp=0/0", aux_grant_cnt, stall_cnt);
    end
`endif
    idle_inputs();
    wlog.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2 nRST = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (wlog.size() != 0 || q_count !== 3'd0) begin
      n_err++; $display("FAIL midreset_stale got writes=%0d q=%0d exp 0/0", wlog.size(), q_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (!last_stall) begin
        pri_wen  = ($urandom % 10) < 6;
        pri_wsel = 5'($urandom % 8);
        pri_wdat = $urandom;
      end
      aux_req  = ($urandom % 10) < 4;
      aux_wsel = 5'($urandom % 8);
      aux_wdat = $urandom;
      tick();
    end
    idle_inputs();
    repeat (DEPTH + 2) tick();
    for (int r = 1; r < 32; r++) begin
      n_cmp++;
      if (tb_rf[r] !== exp_rf[r]) begin
        n_err++; $display("FAIL random_regfile r%0d got=%h exp=%h", r, tb_rf[r], exp_rf[r]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aux_single();
    test_starve();
    test_hazard();
    test_full();
    test_r0_drop();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
